// File: rtl/cpu_pkg.sv
// Shared CPU definitions: access-size encodings, LSU state, bus payload types.
package cpu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;
   localparam int unsigned LSU_CNT_W           = 8;
   localparam int unsigned XLEN                = 32;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_DONE = 2'd2
   } lsu_state_e;

   // Registered bus payload held stable for the whole REQ phase
   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [3:0]      be;
      logic [XLEN-1:0] wdata;
   } lsu_bus_t;

   // Access attributes kept for load-data extraction at ack time
   typedef struct packed {
      logic [1:0] size;
      logic [1:0] addr_lo;
      logic       is_unsigned;
   } lsu_ctx_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic shared by store and load paths: byte enables,
// store replication, misalign detection and load lane select/extension.
module lsu_align
   import cpu_pkg::*;
(
   input  logic [1:0]      size,
   input  logic [1:0]      addr_lo,
   input  logic            is_unsigned,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata_rep,
   output logic            misalign,
   output logic [XLEN-1:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
   assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      be        = 4'b0000;
      wdata_rep = wdata;
      misalign  = 1'b0;
      rdata_ext = rdata;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = is_unsigned ? {24'h000000, byte_sel}
                                    : {{24{byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            be        = 4'b0011 << addr_lo;
            wdata_rep = {2{wdata[15:0]}};
            misalign  = addr_lo[0];
            rdata_ext = is_unsigned ? {16'h0000, half_sel}
                                    : {{16{half_sel[15]}}, half_sel};
         end
         SZ_WORD: begin
            be        = 4'b1111;
            misalign  = (addr_lo != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: req/ack data-bus master with timeout, stalling the
// CPU until the access retires and returning extended load data.
module load_store_unit
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        err_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i
);

   localparam logic [LSU_CNT_W-1:0] CNT_LAST = LSU_CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LSU_CNT_W-1:0] CNT_ONE  = LSU_CNT_W'(1);

   lsu_state_e           state_q, state_d;
   lsu_bus_t             bus_q, bus_d;
   lsu_ctx_t             ctx_q, ctx_d;
   logic                 req_q, req_d;
   logic                 err_q, err_d;
   logic [XLEN-1:0]      rdata_q, rdata_d;
   logic [LSU_CNT_W-1:0] cnt_q, cnt_d;

   logic                 in_idle;
   logic [1:0]           al_size;
   logic [1:0]           al_addr_lo;
   logic                 al_uns;
   logic [3:0]           al_be;
   logic [XLEN-1:0]      al_wdata;
   logic [XLEN-1:0]      al_rdata;
   logic                 al_misalign;
   logic                 access;
   logic                 valid;
   logic                 stall_c;

   // Align logic sees live inputs while accepting, latched attributes during REQ
   assign in_idle    = (state_q == LSU_IDLE);
   assign al_size    = in_idle ? size_i     : ctx_q.size;
   assign al_addr_lo = in_idle ? addr_i[1:0] : ctx_q.addr_lo;
   assign al_uns     = in_idle ? unsigned_i : ctx_q.is_unsigned;

   lsu_align u_align (
      .size        (al_size),
      .addr_lo     (al_addr_lo),
      .is_unsigned (al_uns),
      .wdata       (wdata_i),
      .rdata       (bus_rdata_i),
      .be          (al_be),
      .wdata_rep   (al_wdata),
      .misalign    (al_misalign),
      .rdata_ext   (al_rdata)
   );

   assign access = mem_read_i | mem_write_i;
   assign valid  = (mem_read_i ^ mem_write_i) & (size_i != 2'b11) & ~al_misalign;

   always_comb begin
      state_d = state_q;
      bus_d   = bus_q;
      ctx_d   = ctx_q;
      req_d   = req_q;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      stall_c = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (access && valid) begin
               stall_c        = 1'b1;
               state_d        = LSU_REQ;
               req_d          = 1'b1;
               bus_d.we       = mem_write_i;
               bus_d.addr     = {addr_i[31:2], 2'b00};
               bus_d.be       = al_be;
               bus_d.wdata    = al_wdata;
               ctx_d.size        = size_i;
               ctx_d.addr_lo     = addr_i[1:0];
               ctx_d.is_unsigned = unsigned_i;
               cnt_d          = '0;
            end else if (access) begin
               err_d = 1'b1;
            end
         end
         LSU_REQ: begin
            stall_c = 1'b1;
            if (bus_ack_i) begin
               rdata_d = al_rdata;
               req_d   = 1'b0;
               state_d = LSU_DONE;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               req_d   = 1'b0;
               state_d = LSU_DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         LSU_DONE: state_d = LSU_IDLE;
         default:  state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= LSU_IDLE;
         bus_q   <= '0;
         ctx_q   <= '0;
         req_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bus_q   <= bus_d;
         ctx_q   <= ctx_d;
         req_q   <= req_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stall_o     = stall_c;
   assign err_o       = err_q;
   assign rdata_o     = rdata_q;
   assign bus_req_o   = req_q;
   assign bus_we_o    = bus_q.we;
   assign bus_addr_o  = bus_q.addr;
   assign bus_be_o    = bus_q.be;
   assign bus_wdata_o = bus_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// accesses checked against a byte-lane reference model.
module tb_load_store_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write, uns;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata;
   logic        stall, err, bus_req, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int n_checks = 0;
   int n_fail   = 0;

   load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .mem_read_i  (mem_read),
      .mem_write_i (mem_write),
      .size_i      (size),
      .unsigned_i  (uns),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .rdata_o     (rdata),
      .stall_o     (stall),
      .err_o       (err),
      .bus_req_o   (bus_req),
      .bus_we_o    (bus_we),
      .bus_addr_o  (bus_addr),
      .bus_be_o    (bus_be),
      .bus_wdata_o (bus_wdata),
      .bus_ack_i   (bus_ack),
      .bus_rdata_i (bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: access width in bytes and lane arithmetic
   function automatic int nbytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic bit access_ok(input logic rd, input logic wr, input logic [1:0] sz,
                                    input logic [31:0] a);
      if (rd == wr || sz == 2'b11) return 1'b0;
      return (a % nbytes(sz)) == 0;
   endfunction

   function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
      int lo = int'(a % 4);
      return 4'(((1 << nbytes(sz)) - 1) << lo);
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r;
      int w = 8 * nbytes(sz);
      for (int i = 0; i < 32; i++) r[i] = wd[i % w];
      return r;
   endfunction

   function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic u,
                                            input logic [31:0] a, input logic [31:0] bus);
      longint v, mask;
      int w;
      if (sz == 2'b10) return bus;
      w    = 8 * nbytes(sz);
      v    = longint'(bus >> (8 * (a % 4)));
      mask = (longint'(1) << w) - 1;
      v    = v & mask;
      if (!u && ((v >> (w - 1)) & 1) == 1) v = v | ~mask;
      return 32'(v);
   endfunction

   // One instruction, starting and ending at a negedge with the DUT in IDLE
   task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic u, input logic [31:0] a, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rbus);
      bit ok, acked;
      ok = access_ok(rd, wr, sz, a);
      mem_read = rd; mem_write = wr; size = sz; uns = u; addr = a; wdata = wd;
      #1;
      check_eq("stall_c0", 32'(stall), 32'(ok));
      check_eq("req_c0", 32'(bus_req), 32'd0);
      if (!ok) begin
         @(negedge clk);
         check_eq("err_invalid", 32'(err), 32'(rd | wr));
         check_eq("req_invalid", 32'(bus_req), 32'd0);
         check_eq("stall_invalid", 32'(stall), 32'd0);
         mem_read = 1'b0; mem_write = 1'b0;
         @(negedge clk);
         check_eq("err_clear", 32'(err), 32'd0);
         return;
      end
      acked = 1'b0;
      for (int k = 0; k < TMO && !acked; k++) begin
         @(negedge clk);
         check_eq("req_hold", 32'(bus_req), 32'd1);
         check_eq("stall_req", 32'(stall), 32'd1);
         check_eq("err_req", 32'(err), 32'd0);
         check_eq("we", 32'(bus_we), 32'(wr));
         check_eq("addr", bus_addr, {a[31:2], 2'b00});
         check_eq("be", 32'(bus_be), 32'(exp_be(sz, a)));
         check_eq("wdata", bus_wdata, exp_wdata(sz, wd));
         if (k == ack_at) begin
            bus_ack = 1'b1; bus_rdata = rbus; acked = 1'b1;
         end else begin
            bus_ack = 1'b0; bus_rdata = $urandom;
         end
      end
      @(negedge clk);
      bus_ack = 1'b0;
      check_eq("req_done", 32'(bus_req), 32'd0);
      check_eq("stall_done", 32'(stall), 32'd0);
      check_eq("err_done", 32'(err), 32'(!acked));
      if (!acked) check_eq("rdata_timeout", rdata, 32'd0);
      else if (rd) check_eq("rdata_load", rdata, exp_load(sz, u, a, rbus));
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      check_eq("err_idle", 32'(err), 32'd0);
      check_eq("stall_idle", 32'(stall), 32'd0);
      check_eq("req_idle", 32'(bus_req), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_rdata"}, rdata, 32'd0);
      check_eq({tag, "_err"}, 32'(err), 32'd0);
      check_eq({tag, "_req"}, 32'(bus_req), 32'd0);
      check_eq({tag, "_we"}, 32'(bus_we), 32'd0);
      check_eq({tag, "_addr"}, bus_addr, 32'd0);
      check_eq({tag, "_be"}, 32'(bus_be), 32'd0);
      check_eq({tag, "_wdata"}, bus_wdata, 32'd0);
      check_eq({tag, "_stall"}, 32'(stall), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          sel;
      logic [1:0]  sz;
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; uns = 1'b0;
      addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h5555_5555, 0, 32'hDEAD_BEEF);
      run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h8000_0000);
      check_eq("sbyte_value", rdata, 32'hFFFF_FF80);
      run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h8000_0000);
      check_eq("ubyte_value", rdata, 32'h0000_0080);
      run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234_ABCD, 3, 32'h0);
      run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h0);
      run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h203, 32'h0, 0, 32'h0);
      run_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'h0);
      run_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 32'h0);
      run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h302, 32'h0, TMO + 5, 32'h0);
      run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 1, 32'hF00D_8421);

      // Reset during the second REQ cycle, then a stray ack
      mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h400; wdata = '0;
      @(negedge clk);
      check_eq("rst_req0", 32'(bus_req), 32'd1);
      @(negedge clk);
      check_eq("rst_req1", 32'(bus_req), 32'd1);
      rst = 1'b1; mem_read = 1'b0;
      @(negedge clk);
      check_all_zero("midreq_rst");
      rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      bus_ack = 1'b0;
      check_all_zero("stray_ack");
      @(negedge clk);
      check_all_zero("stray_ack2");

      for (int it = 0; it < 80; it++) begin
         sel = int'($urandom_range(0, 9));
         sz  = 2'($urandom_range(0, 3));
         a   = $urandom;
         if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~(32'(nbytes(sz)) - 32'd1);
         run_access(sel < 5 || sel == 9, (sel >= 5 && sel < 8) || sel == 9, sz,
                    1'($urandom_range(0, 1)), a, $urandom,
                    int'($urandom_range(0, TMO)), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the single-cycle CPU, directly downstream of the ALU: consumes the ALU result as an effective address and the RT register value as store data. Runs a req/ack transaction on an external data bus, holding the CPU (PC and register write) via `stall_o` until the access completes. Returns aligned, extended load data for the register-file write-back mux.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: max REQ cycles without `bus_ack_i` before abort (1..255).

Ports (all synchronous to `clk_i`):
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `mem_read_i` in 1: load requested by the current instruction (from Decoder).
- `mem_write_i` in 1: store requested by the current instruction.
- `size_i` in 2: access size; 00 byte, 01 half, 10 word, 11 illegal.
- `unsigned_i` in 1: zero-extend loads when 1, sign-extend when 0.
- `addr_i` in 32: effective address (ALU result).
- `wdata_i` in 32: store data (RT data, low bits significant).
- `rdata_o` out 32: extended load data, valid in DONE.
- `stall_o` out 1: hold PC and suppress RegWrite while 1.
- `err_o` out 1: one-cycle pulse on misalign, illegal request or timeout.
- `bus_req_o` out 1: bus request.
- `bus_we_o` out 1: 1 = write.
- `bus_addr_o` out 32: word address, bits [1:0] forced to 0.
- `bus_be_o` out 4: byte enables, little-endian.
- `bus_wdata_o` out 32: lane-replicated store data.
- `bus_ack_i` in 1: transaction complete.
- `bus_rdata_i` in 32: read data, valid when `bus_ack_i`=1.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE with a valid access (exactly one of read/write, legal size, aligned): latch addr, we, be, wdata into bus registers, clear timeout counter, go to REQ. `stall_o`=1 combinationally in this cycle.
- Invalid request: no bus activity, `err_o` pulses next cycle, `stall_o`=0, stay IDLE. Invalid means both read and write, `size_i`=11, half with addr[0]=1, or word with addr[1:0]≠0.
- REQ: `bus_req_o`=1; all bus outputs stay stable until ack.
  - On `bus_ack_i`=1: load data is extracted and extended into the `rdata_o` register; go to DONE.
  - Otherwise the counter increments. If the counter equals `TIMEOUT_CYCLES`-1 with no ack: `rdata_o`←0, `err_o` pulses, go to DONE.
- DONE: `stall_o`=0, `bus_req_o`=0. The CPU retires the instruction at this edge. Go to IDLE unconditionally; requests are not sampled in DONE.
- Byte enables: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
- Store data: byte replicated ×4; half replicated ×2.
- Load extraction: select the lane by addr[1:0], then extend to 32 bits per `unsigned_i`. For word accesses `unsigned_i` is ignored.
- `bus_ack_i` is ignored outside REQ.

## Timing
- Reset (edge with `rst_i`=1) gives state IDLE and all outputs 0: `rdata_o`, `err_o`, `bus_req_o`, `bus_we_o`, `bus_addr_o`, `bus_be_o`, `bus_wdata_o`, counter.
- `stall_o` reads 0 out of reset because no request is present.
- Reset mid-REQ abandons the transaction: `bus_req_o` drops the next cycle, and no `err_o` is raised.
- Minimum latency is 3 cycles per memory instruction:
  - C0: IDLE, stall.
  - C1: REQ with ack.
  - C2: DONE.
- Every wait cycle in REQ adds one cycle.
- `stall_o` = (IDLE ∧ valid request) ∨ REQ. This is combinational from the inputs so the PC holds at the C0 edge.
- All bus outputs and `rdata_o` are registered.
- Timeout: at most `TIMEOUT_CYCLES` cycles in REQ.

## Structure
- Shared package `cpu_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`.
  - LSU state enum.
  - default timeout constant.
- Sub-module `lsu_align` (combinational), shared by the store and load paths:
  - byte-enable generation.
  - store-data replication.
  - misalign check.
  - load lane select and extension.
- `load_store_unit` holds the FSM, timeout counter and bus registers.

## Test plan
- Word load: addr 0x100, ack in first REQ cycle, bus_rdata 0xDEADBEEF. Expect `rdata_o`=0xDEADBEEF in DONE, `bus_be_o`=1111, and `stall_o` high for exactly 2 cycles.
- Signed byte load: addr 0x103, bus_rdata 0x80000000, `unsigned_i`=0. Expect be 1000 and `rdata_o`=0xFFFFFF80. Repeat with `unsigned_i`=1: expect 0x00000080.
- Half store: addr 0x102, wdata 0x1234ABCD, ack after 3 wait cycles. Expect be 1100, `bus_wdata_o`=0xABCDABCD, and outputs stable through the waits.
- Misaligned word load: addr 0x101. Expect no `bus_req_o`, `err_o` pulse, and `stall_o` never asserted beyond the request cycle.
- Timeout with `TIMEOUT_CYCLES`=4 and no ack. Expect 4 REQ cycles, then DONE with `rdata_o`=0 and a 1-cycle `err_o`.
- Reset asserted in the second REQ cycle. Expect IDLE and all outputs 0 next cycle, and a spurious `bus_ack_i` afterwards ignored.
